// File: rtl/ucc_pkg.sv
// Shared definitions for the universal-counter-cell timer: cell modes,
// FSM state encoding and the state-to-mode decode.
package ucc_pkg;

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_UP   = 2'b01;
   localparam logic [1:0] MODE_DOWN = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_LOAD   = 2'b01,
      S_RUN    = 2'b10,
      S_EXPIRE = 2'b11
   } state_t;

   // Cell mode is a pure function of state (and the direction latched in LOAD).
   function automatic logic [1:0] mode_for(input state_t st, input logic dir_q);
      logic [1:0] m;
      m = MODE_HOLD;
      case (st)
         S_LOAD:  m = MODE_LOAD;
         S_RUN:   m = dir_q ? MODE_UP : MODE_DOWN;
         default: m = MODE_HOLD;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/ucc_cell.sv
// Universal counter cell: combinational hold / up / down / load of fin,
// with carry (up) or borrow (down) on cout and a pass-through of the mode.
module ucc_cell
   import ucc_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] fin,
   input  logic [WIDTH-1:0] pin,
   input  logic [1:0]       min,
   input  logic             cin,
   output logic [WIDTH-1:0] fout,
   output logic             cout,
   output logic [1:0]       mout
);

   assign mout = min;

   always_comb begin
      fout = fin;
      cout = 1'b0;
      case (min)
         MODE_UP: begin
            fout = fin + WIDTH'(cin);
            cout = cin & (&fin);
         end
         MODE_DOWN: begin
            fout = fin - WIDTH'(cin);
            cout = cin & ~(|fin);
         end
         MODE_LOAD: begin
            fout = pin;
         end
         default: begin
            fout = fin;
            cout = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/ucc_timer8.sv
// Programmable timer: FSM steering a universal counter cell whose result is
// held in a register and fed back; carry/borrow out marks terminal count.
module ucc_timer8
   import ucc_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             tick,
   input  logic             dir,
   input  logic             auto_reload,
   input  logic [WIDTH-1:0] reload_val,
   output logic [WIDTH-1:0] cnt_out,
   output logic [1:0]       mode_out,
   output logic             busy,
   output logic             expired
);

   state_t           state;
   logic [WIDTH-1:0] cnt;
   logic             dir_q;

   logic [1:0]       cell_mode;
   logic             cell_cin;
   logic [WIDTH-1:0] cell_fout;
   logic             cell_cout;
   logic [1:0]       cell_mout;

   assign cell_mode = mode_for(state, dir_q);
   // tick only reaches the cell while counting
   assign cell_cin  = (state == S_RUN) & tick;

   ucc_cell #(.WIDTH(WIDTH)) u_cell (
      .fin  (cnt),
      .pin  (reload_val),
      .min  (cell_mode),
      .cin  (cell_cin),
      .fout (cell_fout),
      .cout (cell_cout),
      .mout (cell_mout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         cnt   <= '0;
         dir_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start && !stop)
                  state <= S_LOAD;
            end
            S_LOAD: begin
               if (stop) begin
                  state <= S_IDLE;
               end else begin
                  cnt   <= cell_fout;
                  dir_q <= dir;
                  state <= start ? S_LOAD : S_RUN;
               end
            end
            S_RUN: begin
               // stop and restart both discard this cycle's step and any terminal count
               if (stop) begin
                  state <= S_IDLE;
               end else if (start) begin
                  state <= S_LOAD;
               end else begin
                  cnt <= cell_fout;
                  if (cell_cout)
                     state <= S_EXPIRE;
               end
            end
            S_EXPIRE: begin
               if (stop)
                  state <= S_IDLE;
               else if (start || auto_reload)
                  state <= S_LOAD;
               else
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign cnt_out  = cnt;
   assign mode_out = cell_mout;
   assign busy     = (state != S_IDLE);
   assign expired  = (state == S_EXPIRE);

endmodule
